// File: rtl/boot_loader_seq.sv
// Boot sequencer: optionally zero-fills data RAM, streams a program image into
// instruction memory while holding the core in reset, then releases the core
// and flags when its PC reaches the programmed halt address.
//
//   state | meaning
//   IDLE  | after reset; core held in reset, waiting for start
//   CLEAR | one zero write per cycle across all of data RAM
//   LOAD  | accepting stream words, one imem write per handshake
//   HOLD  | core reset held RST_HOLD cycles past the last write
//   RUN   | core released; watching core_pc for halt_addr
module boot_loader_seq #(
  parameter int DW         = 32,
  parameter int AW         = 32,
  parameter int DMEM_DEPTH = 1024,
  parameter int IMEM_DEPTH = 256,
  parameter int RST_HOLD   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic                          clear_en,
  input  logic [$clog2(IMEM_DEPTH):0]   load_len,
  input  logic [AW-1:0]                 halt_addr,
  input  logic                          s_valid,
  input  logic [DW-1:0]                 s_data,
  output logic                          s_ready,
  output logic                          dmem_we,
  output logic [AW-1:0]                 dmem_addr,
  output logic [DW-1:0]                 dmem_wdata,
  output logic                          imem_we,
  output logic [AW-1:0]                 imem_addr,
  output logic [DW-1:0]                 imem_wdata,
  output logic                          core_rst,
  input  logic [AW-1:0]                 core_pc,
  output logic                          busy,
  output logic                          halted,
  output logic                          err
);

  localparam int LW = $clog2(IMEM_DEPTH) + 1;
  localparam int CW = $clog2(DMEM_DEPTH + 1);
  localparam int HW = $clog2(RST_HOLD + 1);
  localparam int BS = DW / 8;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    CLEAR = 3'd1,
    LOAD  = 3'd2,
    HOLD  = 3'd3,
    RUN   = 3'd4
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   clr_left_q, clr_left_d;
  logic [LW-1:0]   ld_cnt_q, ld_cnt_d;
  logic [LW-1:0]   len_eff_q, len_eff_d;
  logic [AW-1:0]   ld_addr_q, ld_addr_d;
  logic [HW-1:0]   hold_left_q, hold_left_d;

  logic            dmem_we_d, imem_we_d, core_rst_d, busy_d, halted_d, err_d;
  logic [AW-1:0]   dmem_addr_d, imem_addr_d;
  logic [DW-1:0]   imem_wdata_d;
  logic            hs;

  assign s_ready    = (state_q == LOAD) && (ld_cnt_q < len_eff_q);
  assign hs         = s_valid && s_ready;
  assign dmem_wdata = '0;

  // State and all registered outputs; rst aborts straight to the idle values.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      clr_left_q  <= '0;
      ld_cnt_q    <= '0;
      len_eff_q   <= '0;
      ld_addr_q   <= '0;
      hold_left_q <= '0;
      dmem_we     <= 1'b0;
      dmem_addr   <= '0;
      imem_we     <= 1'b0;
      imem_addr   <= '0;
      imem_wdata  <= '0;
      core_rst    <= 1'b1;
      busy        <= 1'b0;
      halted      <= 1'b0;
      err         <= 1'b0;
    end else begin
      state_q     <= state_d;
      clr_left_q  <= clr_left_d;
      ld_cnt_q    <= ld_cnt_d;
      len_eff_q   <= len_eff_d;
      ld_addr_q   <= ld_addr_d;
      hold_left_q <= hold_left_d;
      dmem_we     <= dmem_we_d;
      dmem_addr   <= dmem_addr_d;
      imem_we     <= imem_we_d;
      imem_addr   <= imem_addr_d;
      imem_wdata  <= imem_wdata_d;
      core_rst    <= core_rst_d;
      busy        <= busy_d;
      halted      <= halted_d;
      err         <= err_d;
    end
  end

  // Next state and next values of the registered outputs.
  always_comb begin
    state_d      = state_q;
    clr_left_d   = clr_left_q;
    ld_cnt_d     = ld_cnt_q;
    len_eff_d    = len_eff_q;
    ld_addr_d    = ld_addr_q;
    hold_left_d  = hold_left_q;
    dmem_we_d    = 1'b0;
    dmem_addr_d  = dmem_addr;
    imem_we_d    = 1'b0;
    imem_addr_d  = imem_addr;
    imem_wdata_d = imem_wdata;
    halted_d     = halted;
    err_d        = err;

    case (state_q)
      IDLE, RUN: begin
        if (state_q == RUN && core_pc == halt_addr) begin
          halted_d = 1'b1;
        end
        // A start here (including from RUN) begins a fresh sequence.
        if (start) begin
          halted_d  = 1'b0;
          ld_cnt_d  = '0;
          ld_addr_d = '0;
          if (load_len > LW'(IMEM_DEPTH)) begin
            err_d     = 1'b1;
            len_eff_d = LW'(IMEM_DEPTH);
          end else begin
            len_eff_d = load_len;
          end
          if (clear_en) begin
            state_d     = CLEAR;
            clr_left_d  = CW'(DMEM_DEPTH - 1);
            dmem_we_d   = 1'b1;
            dmem_addr_d = '0;
          end else begin
            state_d = LOAD;
          end
        end
      end
      CLEAR: begin
        if (clr_left_q == '0) begin
          state_d = LOAD;
        end else begin
          clr_left_d  = clr_left_q - CW'(1);
          dmem_we_d   = 1'b1;
          dmem_addr_d = dmem_addr + AW'(BS);
        end
      end
      LOAD: begin
        if (hs) begin
          imem_we_d    = 1'b1;
          imem_addr_d  = ld_addr_q;
          imem_wdata_d = s_data;
          ld_addr_d    = ld_addr_q + AW'(BS);
          ld_cnt_d     = ld_cnt_q + LW'(1);
        end
        // Leaves on the last handshake, or at once when nothing is to be loaded.
        if (ld_cnt_d == len_eff_q) begin
          state_d     = HOLD;
          hold_left_d = HW'(RST_HOLD);
        end
      end
      HOLD: begin
        if (hold_left_q == '0) begin
          state_d = RUN;
        end else begin
          hold_left_d = hold_left_q - HW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    core_rst_d = (state_d != RUN);
    busy_d     = (state_d == CLEAR) || (state_d == LOAD) || (state_d == HOLD);
  end

endmodule
